// File: rtl/lift_pkg.sv
// lift_pkg: shared FSM state encoding, travel directions and pending-call mask helpers for lift_dispatch_ctrl
package lift_pkg;
  localparam int MAX_FLOORS = 16;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_UP   = 3'd1,
    MOVE_DOWN = 3'd2,
    DOOR_OPEN = 3'd3,
    FAULT     = 3'd4
  } state_t;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  function automatic logic any_above(input logic [MAX_FLOORS-1:0] m, input logic [3:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) r |= m[i] & (i > int'(idx));
    return r;
  endfunction
  function automatic logic any_below(input logic [MAX_FLOORS-1:0] m, input logic [3:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) r |= m[i] & (i < int'(idx));
    return r;
  endfunction
endpackage

// File: rtl/lift_door_timer.sv
// lift_door_timer: door dwell counter (clk, rst, load reloads DOOR_CYCLES-1, en decrements, done when zero)
module lift_door_timer #(
  parameter int DOOR_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);
  localparam int CW = $clog2(DOOR_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? CW'(DOOR_CYCLES - 1) : (en && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign done = cnt_q == '0;
endmodule

// File: rtl/lift_dispatch_ctrl.sv
// lift_dispatch_ctrl: SCAN lift dispatcher (in: clk, rst, call_req, floor_sensor; out: motor_up, motor_down, door_open, cur_floor, pending, busy, fault; LIFT_WATCHDOG_EN adds travel watchdog)
module lift_dispatch_ctrl
  import lift_pkg::*;
#(
  parameter int N_FLOORS = 4,
  parameter int DOOR_CYCLES = 8,
  parameter int MAX_TRAVEL = 1000,
  localparam int FLOOR_W = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] call_req,
  input  logic [N_FLOORS-1:0] floor_sensor,
  output logic                motor_up,
  output logic                motor_down,
  output logic                door_open,
  output logic [FLOOR_W-1:0]  cur_floor,
  output logic [N_FLOORS-1:0] pending,
  output logic                busy,
  output logic                fault
);
  state_t state_q, state_d;
  logic [FLOOR_W-1:0] cur_floor_q, cur_floor_d, sens_idx;
  logic [N_FLOORS-1:0] pending_q, pending_d, blk, clr;
  logic last_dir_q, last_dir_d;
  logic sens_hit, sens_multi, sens_valid;
  logic here, above, below, call_here, enter_door, enter_move, door_load, door_done;
  logic motor_up_q, motor_down_q, door_open_q, busy_q;
`ifdef LIFT_WATCHDOG_EN
  localparam int TW = $clog2(MAX_TRAVEL + 1);
  logic [TW-1:0] trav_q, trav_d;
  logic sens_chg, moving, fault_q;
`endif
  always_comb begin
    sens_idx = '0;
    sens_hit = 1'b0;
    sens_multi = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (floor_sensor[i]) begin
        sens_multi = sens_multi | sens_hit;
        sens_hit = 1'b1;
        sens_idx = FLOOR_W'(i);
      end
    end
    sens_valid = sens_hit & ~sens_multi;
  end
  always_comb begin
    cur_floor_d = sens_valid ? sens_idx : cur_floor_q;
    here = pending_q[cur_floor_q];
    above = any_above(MAX_FLOORS'(pending_q), 4'(cur_floor_q));
    below = any_below(MAX_FLOORS'(pending_q), 4'(cur_floor_q));
    call_here = call_req[cur_floor_q];
    case (state_q)
      IDLE:      state_d = here ? DOOR_OPEN : (above && (last_dir_q == DIR_UP || !below)) ? MOVE_UP : below ? MOVE_DOWN : IDLE;
      MOVE_UP:   state_d = (sens_valid && pending_q[sens_idx]) ? DOOR_OPEN : (sens_valid && sens_idx == FLOOR_W'(N_FLOORS - 1)) ? IDLE : MOVE_UP;
      MOVE_DOWN: state_d = (sens_valid && pending_q[sens_idx]) ? DOOR_OPEN : (sens_valid && sens_idx == '0) ? IDLE : MOVE_DOWN;
      DOOR_OPEN: state_d = (door_done && !call_here) ? IDLE : DOOR_OPEN;
      default:   state_d = state_q;
    endcase
`ifdef LIFT_WATCHDOG_EN
    moving = state_q == MOVE_UP || state_q == MOVE_DOWN;
    sens_chg = sens_valid && sens_idx != cur_floor_q;
    if (moving && state_d == state_q && !sens_chg && trav_q == TW'(MAX_TRAVEL - 1)) state_d = FAULT;
`endif
    enter_door = state_d == DOOR_OPEN && state_q != DOOR_OPEN;
    enter_move = (state_d == MOVE_UP || state_d == MOVE_DOWN) && state_d != state_q;
    door_load = enter_door || (state_q == DOOR_OPEN && call_here);
    // a call to the floor whose door is already open only extends the dwell
    blk = (state_q == DOOR_OPEN) ? N_FLOORS'(1) << cur_floor_q : '0;
    clr = enter_door ? N_FLOORS'(1) << cur_floor_d : '0;
    pending_d = (pending_q | (call_req & ~blk)) & ~clr;
    last_dir_d = enter_move ? (state_d == MOVE_UP ? DIR_UP : DIR_DOWN) : last_dir_q;
`ifdef LIFT_WATCHDOG_EN
    trav_d = (enter_move || sens_chg) ? '0 : moving ? trav_q + TW'(1) : trav_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_floor_q <= '0;
      pending_q <= '0;
      last_dir_q <= DIR_UP;
      motor_up_q <= 1'b0;
      motor_down_q <= 1'b0;
      door_open_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef LIFT_WATCHDOG_EN
      trav_q <= '0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cur_floor_q <= cur_floor_d;
      pending_q <= pending_d;
      last_dir_q <= last_dir_d;
      motor_up_q <= state_d == MOVE_UP;
      motor_down_q <= state_d == MOVE_DOWN;
      door_open_q <= state_d == DOOR_OPEN;
      busy_q <= state_d != IDLE;
`ifdef LIFT_WATCHDOG_EN
      trav_q <= trav_d;
      fault_q <= state_d == FAULT;
`endif
    end
  end
  lift_door_timer #(.DOOR_CYCLES(DOOR_CYCLES)) u_door (
    .clk (clk),
    .rst (rst),
    .load(door_load),
    .en  (state_q == DOOR_OPEN),
    .done(door_done)
  );
  assign motor_up = motor_up_q;
  assign motor_down = motor_down_q;
  assign door_open = door_open_q;
  assign cur_floor = cur_floor_q;
  assign pending = pending_q;
  assign busy = busy_q;
`ifdef LIFT_WATCHDOG_EN
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif
endmodule
